// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says engine: FSM state encoding,
// LFSR feedback taps and the LFSR-to-symbol mapping.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        WIN,
        LOSE
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Low `width` bits of the LFSR; the all-zero code means "no button", so it becomes all-ones.
    function automatic logic [15:0] lfsr_symbol(input logic [15:0] lfsr, input int unsigned width);
        logic [15:0] mask;
        mask = 16'hFFFF >> (16 - width);
        return ((lfsr & mask) == 16'h0000) ? mask : (lfsr & mask);
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// 16-bit right-shifting Galois LFSR that advances only when step is high.
module simon_lfsr16
    import simon_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (step) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/simon_says_core.sv
// Simon Says game engine: grows an LFSR-generated sequence one symbol per round,
// plays it back on show_comb and checks the player's presses on knapp_comb.
module simon_says_core
    import simon_pkg::*;
#(
    parameter int          KNAPP_W        = 2,
    parameter int          MAX_LEN        = 32,
    parameter int          COUNT_W        = 6,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          GAP_CYCLES     = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KNAPP_W-1:0] knapp_comb,
    output logic [KNAPP_W-1:0] show_comb,
    output logic               correct_out,
    output logic [COUNT_W-1:0] count_out,
    output logic               game_over,
    output logic               win
);

    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PH_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0]    SHOW_LAST = PH_W'(SHOW_CYCLES - 1);
    localparam logic [PH_W-1:0]    GAP_LAST  = PH_W'(GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] LEN_MAX   = COUNT_W'(MAX_LEN);

    if (2 ** COUNT_W <= MAX_LEN) begin : g_count_w_check
        $error("simon_says_core: COUNT_W too narrow to hold MAX_LEN");
    end
    if (LFSR_SEED == 16'h0000) begin : g_seed_check
        $error("simon_says_core: LFSR_SEED must be nonzero");
    end

    state_t             state_reg;
    logic [COUNT_W-1:0] len_reg;
    logic [COUNT_W-1:0] idx_reg;
    logic [COUNT_W-1:0] idx_next;
    logic [PH_W-1:0]    phase_cnt_reg;
    logic [TO_W-1:0]    idle_cnt_reg;
    logic               prev_zero_reg;
    logic [15:0]        lfsr_state;
    logic               lfsr_step;
    logic               press;
    logic [KNAPP_W-1:0] new_sym;
    logic [KNAPP_W-1:0] cur_sym;
    logic [KNAPP_W-1:0] next_sym;

    logic [KNAPP_W-1:0] seq_mem [MAX_LEN];

    assign lfsr_step = (state_reg == ADD);
    assign press     = (knapp_comb != '0) && prev_zero_reg;
    assign new_sym   = KNAPP_W'(lfsr_symbol(lfsr_state, KNAPP_W));
    assign idx_next  = idx_reg + COUNT_W'(1);
    assign cur_sym   = seq_mem[idx_reg[ADDR_W-1:0]];
    assign next_sym  = seq_mem[idx_next[ADDR_W-1:0]];

    simon_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .state (lfsr_state)
    );

    // Sequence storage is deliberately left unreset; len_reg bounds every read.
    always_ff @(posedge clk) begin
        if (state_reg == ADD) begin
            seq_mem[len_reg[ADDR_W-1:0]] <= new_sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            idx_reg       <= '0;
            phase_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            prev_zero_reg <= 1'b1;
            show_comb     <= '0;
            correct_out   <= 1'b0;
            count_out     <= '0;
            game_over     <= 1'b0;
            win           <= 1'b0;
        end else begin
            prev_zero_reg <= (knapp_comb == '0);
            correct_out   <= 1'b0;
            case (state_reg)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        len_reg   <= '0;
                        idx_reg   <= '0;
                        count_out <= '0;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    len_reg       <= len_reg + COUNT_W'(1);
                    idx_reg       <= '0;
                    phase_cnt_reg <= '0;
                    // On the first round seq_mem[0] is being written this very cycle.
                    show_comb     <= (len_reg == '0) ? new_sym : seq_mem[{ADDR_W{1'b0}}];
                    state_reg     <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (phase_cnt_reg == SHOW_LAST) begin
                        phase_cnt_reg <= '0;
                        show_comb     <= '0;
                        state_reg     <= SHOW_OFF;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
                    end
                end
                SHOW_OFF: begin
                    if (phase_cnt_reg == GAP_LAST) begin
                        phase_cnt_reg <= '0;
                        if (idx_next < len_reg) begin
                            idx_reg   <= idx_next;
                            show_comb <= next_sym;
                            state_reg <= SHOW_ON;
                        end else begin
                            idx_reg      <= '0;
                            idle_cnt_reg <= '0;
                            state_reg    <= WAIT_IN;
                        end
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PH_W'(1);
                    end
                end
                WAIT_IN: begin
                    // A press beats a simultaneous timeout expiry.
                    if (press) begin
                        idle_cnt_reg <= '0;
                        if (knapp_comb != cur_sym) begin
                            game_over <= 1'b1;
                            state_reg <= LOSE;
                        end else if (idx_next < len_reg) begin
                            idx_reg <= idx_next;
                        end else begin
                            correct_out <= 1'b1;
                            count_out   <= len_reg;
                            idx_reg     <= '0;
                            if (len_reg == LEN_MAX) begin
                                win       <= 1'b1;
                                state_reg <= WIN;
                            end else begin
                                state_reg <= ADD;
                            end
                        end
                    end else if (idle_cnt_reg == TO_LAST) begin
                        game_over <= 1'b1;
                        state_reg <= LOSE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
